// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//
// Multi-cycle fetch/execute controller for the 13-bit accumulator CPU.
// Owns the program counter, addresses the synchronous program memory,
// holds the fetched word in the instruction register, inserts a wait
// cycle for data-memory operand reads, gates the decoder strobes down to a
// single EXEC cycle and executes the control-flow opcodes JMP, JZ, HALT.
//
// Ports
//   Clk             in   system clock, rising edge
//   nRst            in   asynchronous active-low reset
//   Start           in   leaves IDLE or HALT; ignored while running
//   PM_Addr         out  program-memory address (the PC)
//   PM_Ins          in   program-memory data, valid one cycle after PM_Addr
//   Ins             out  instruction register, feeds the decoder
//   Dec_Reg_CE      in   raw decoder register-file enable
//   Dec_Accu_CE     in   raw decoder accumulator enable
//   Dec_Carry_CE    in   raw decoder carry enable
//   Dec_DataMem_WE  in   raw decoder data-memory write enable
//   Reg_CE          out  gated register-file enable
//   Accu_CE         out  gated accumulator enable
//   Carry_CE        out  gated carry enable
//   DataMem_WE      out  gated data-memory write enable
//   Zero            in   accumulator == 0, sampled in EXEC
//   Running         out  high in FETCH, LATCH, MEMRD, EXEC
//   Halted          out  high in HALT
// ---------------------------------------------------------------------------
module control_sequencer #(
  parameter int PC_WIDTH  = 8,
  parameter int INS_WIDTH = 13
) (
  input  logic                 Clk,
  input  logic                 nRst,
  input  logic                 Start,
  output logic [PC_WIDTH-1:0]  PM_Addr,
  input  logic [INS_WIDTH-1:0] PM_Ins,
  output logic [INS_WIDTH-1:0] Ins,
  input  logic                 Dec_Reg_CE,
  input  logic                 Dec_Accu_CE,
  input  logic                 Dec_Carry_CE,
  input  logic                 Dec_DataMem_WE,
  output logic                 Reg_CE,
  output logic                 Accu_CE,
  output logic                 Carry_CE,
  output logic                 DataMem_WE,
  input  logic                 Zero,
  output logic                 Running,
  output logic                 Halted
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_MEMRD = 3'd3,
    ST_EXEC  = 3'd4,
    ST_HALT  = 3'd5
  } state_t;

  // Opcode field is the top five instruction bits; top two are the section.
  localparam logic [1:0] SEC_DM_ALU = 2'b01;
  localparam logic [4:0] OP_LD_DM   = 5'b11001;
  localparam logic [4:0] OP_JMP     = 5'b11101;
  localparam logic [4:0] OP_JZ      = 5'b11110;
  localparam logic [4:0] OP_HALT    = 5'b11111;

  localparam logic [PC_WIDTH-1:0]  PC_ZERO  = {PC_WIDTH{1'b0}};
  localparam logic [PC_WIDTH-1:0]  PC_ONE   = {{(PC_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [INS_WIDTH-1:0] INS_ZERO = {INS_WIDTH{1'b0}};

  // Instructions whose operand comes from data memory need one extra
  // cycle so the synchronous data-memory read is valid in EXEC.
  function automatic logic needs_memrd(input logic [4:0] op);
    needs_memrd = (op[4:3] == SEC_DM_ALU) || (op == OP_LD_DM);
  endfunction

  state_t                 state_r;
  state_t                 state_s;
  logic [PC_WIDTH-1:0]    pc_r;
  logic [PC_WIDTH-1:0]    pc_s;
  logic [INS_WIDTH-1:0]   ir_r;
  logic [INS_WIDTH-1:0]   ir_s;

  logic [4:0]             ir_op_s;
  logic [4:0]             pm_op_s;
  logic [PC_WIDTH-1:0]    jump_target_s;
  logic [PC_WIDTH-1:0]    pc_inc_s;
  logic                   exec_s;

  assign ir_op_s       = ir_r[INS_WIDTH-1 -: 5];
  assign pm_op_s       = PM_Ins[INS_WIDTH-1 -: 5];
  assign jump_target_s = ir_r[PC_WIDTH-1:0];
  // Natural modulo-2^PC_WIDTH wrap, no overflow flag.
  assign pc_inc_s      = pc_r + PC_ONE;

  // State, program counter and instruction register.
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state_r <= ST_IDLE;
      pc_r    <= PC_ZERO;
      ir_r    <= INS_ZERO;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      ir_r    <= ir_s;
    end
  end

  // Next-state, next-PC and instruction-latch decision.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    ir_s    = ir_r;
    case (state_r)
      ST_IDLE: begin
        pc_s = PC_ZERO;
        if (Start) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // PM_Addr is already the PC; data arrives next cycle.
        state_s = ST_LATCH;
      end
      ST_LATCH: begin
        ir_s = PM_Ins;
        if (needs_memrd(pm_op_s)) begin
          state_s = ST_MEMRD;
        end else begin
          state_s = ST_EXEC;
        end
      end
      ST_MEMRD: begin
        state_s = ST_EXEC;
      end
      ST_EXEC: begin
        case (ir_op_s)
          OP_JMP: begin
            pc_s    = jump_target_s;
            state_s = ST_FETCH;
          end
          OP_JZ: begin
            // Zero still reflects the accumulator before this instruction.
            if (Zero) begin
              pc_s = jump_target_s;
            end else begin
              pc_s = pc_inc_s;
            end
            state_s = ST_FETCH;
          end
          OP_HALT: begin
            pc_s    = pc_r;
            state_s = ST_HALT;
          end
          default: begin
            pc_s    = pc_inc_s;
            state_s = ST_FETCH;
          end
        endcase
      end
      ST_HALT: begin
        if (Start) begin
          pc_s    = PC_ZERO;
          state_s = ST_FETCH;
        end else begin
          state_s = ST_HALT;
        end
      end
      default: begin
        state_s = ST_IDLE;
        pc_s    = PC_ZERO;
      end
    endcase
  end

  // Strobes follow the state register directly so an asynchronous reset
  // in the middle of EXEC drops them at once.
  assign exec_s     = (state_r == ST_EXEC);
  assign Reg_CE     = Dec_Reg_CE     & exec_s;
  assign Accu_CE    = Dec_Accu_CE    & exec_s;
  assign Carry_CE   = Dec_Carry_CE   & exec_s;
  assign DataMem_WE = Dec_DataMem_WE & exec_s;

  assign Running = (state_r == ST_FETCH) || (state_r == ST_LATCH) ||
                   (state_r == ST_MEMRD) || (state_r == ST_EXEC);
  assign Halted  = (state_r == ST_HALT);

  assign PM_Addr = pc_r;
  assign Ins     = ir_r;

endmodule

// File: tb/tb_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_sequencer
//
// Directed bench for control_sequencer. Provides a synchronous program
// memory model and a small decoder model driving the raw Dec_* strobes
// from Ins, then walks hand-computed cycle tables per scenario.
// Cycle 1 is the FETCH cycle that follows the edge sampling Start.
// ---------------------------------------------------------------------------
module tb_control_sequencer;

  logic        Clk;
  logic        nRst;
  logic        Start;
  logic [7:0]  PM_Addr;
  logic [12:0] PM_Ins;
  logic [12:0] Ins;
  logic        Dec_Reg_CE;
  logic        Dec_Accu_CE;
  logic        Dec_Carry_CE;
  logic        Dec_DataMem_WE;
  logic        Reg_CE;
  logic        Accu_CE;
  logic        Carry_CE;
  logic        DataMem_WE;
  logic        Zero;
  logic        Running;
  logic        Halted;

  logic        force_dec;
  logic [12:0] pm [256];
  logic [4:0]  op;
  logic [3:0]  stb;

  int vectors;
  int miscompares;

  control_sequencer #(.PC_WIDTH(8), .INS_WIDTH(13)) dut (
    .Clk            (Clk),
    .nRst           (nRst),
    .Start          (Start),
    .PM_Addr        (PM_Addr),
    .PM_Ins         (PM_Ins),
    .Ins            (Ins),
    .Dec_Reg_CE     (Dec_Reg_CE),
    .Dec_Accu_CE    (Dec_Accu_CE),
    .Dec_Carry_CE   (Dec_Carry_CE),
    .Dec_DataMem_WE (Dec_DataMem_WE),
    .Reg_CE         (Reg_CE),
    .Accu_CE        (Accu_CE),
    .Carry_CE       (Carry_CE),
    .DataMem_WE     (DataMem_WE),
    .Zero           (Zero),
    .Running        (Running),
    .Halted         (Halted)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // synchronous program memory: data valid one cycle after the address
  always @(posedge Clk) PM_Ins <= pm[PM_Addr];

  // decoder model: raw strobes are live whenever Ins holds a matching op
  assign op             = Ins[12:8];
  assign Dec_Accu_CE    = force_dec | (Ins[12:11] == 2'b01) |
                          (op == 5'b11000) | (op == 5'b11001) | (op == 5'b11010);
  assign Dec_Carry_CE   = force_dec | (Ins[12:11] == 2'b01);
  assign Dec_Reg_CE     = force_dec | (op == 5'b11011);
  assign Dec_DataMem_WE = force_dec | (op == 5'b11100);
  assign stb            = {Reg_CE, Accu_CE, Carry_CE, DataMem_WE};

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Start     = 1'b0;
    Zero      = 1'b0;
    force_dec = 1'b0;
    foreach (pm[i]) pm[i] = 13'h0000;
    nRst = 1'b0;
    #2;
    nRst = 1'b1;
    tick();
  endtask

  task automatic start_prog();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic test_reset();
    nRst      = 1'b0;
    Start     = 1'b0;
    Zero      = 1'b0;
    force_dec = 1'b1;
    foreach (pm[i]) pm[i] = 13'h0000;
    #2;
    vectors++;
    if (stb !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b expected %b", stb, 4'b0000);
    end
    vectors++;
    if (PM_Addr !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_pm_addr: got %h expected %h", PM_Addr, 8'h00);
    end
    vectors++;
    if (Ins !== 13'h0000) begin
      miscompares++;
      $display("FAIL reset_ins: got %h expected %h", Ins, 13'h0000);
    end
    vectors++;
    if (Running !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_running: got %b expected %b", Running, 1'b0);
    end
    vectors++;
    if (Halted !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_halted: got %b expected %b", Halted, 1'b0);
    end
    tick();
    force_dec = 1'b0;
    nRst      = 1'b1;
    tick();
  endtask

  task automatic test_straight_line();
    logic [7:0] exp_pc  [9];
    logic [3:0] exp_stb [9];
    exp_pc  = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02};
    exp_stb = '{4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b1000,
                4'b0000, 4'b0000, 4'b0100};
    do_reset();
    pm[0] = 13'h1A05;  // LD_IMD 0x05
    pm[1] = 13'h1B00;  // ST_R R1
    pm[2] = 13'h1A07;  // LD_IMD 0x07
    start_prog();
    for (int c = 0; c < 9; c++) begin
      vectors++;
      if (PM_Addr !== exp_pc[c]) begin
        miscompares++;
        $display("FAIL straight_pc cycle %0d: got %h expected %h", c + 1, PM_Addr, exp_pc[c]);
      end
      vectors++;
      if (stb !== exp_stb[c]) begin
        miscompares++;
        $display("FAIL straight_strobes cycle %0d: got %b expected %b", c + 1, stb, exp_stb[c]);
      end
      vectors++;
      if (Running !== 1'b1) begin
        miscompares++;
        $display("FAIL straight_running cycle %0d: got %b expected %b", c + 1, Running, 1'b1);
      end
      if (c == 5) begin
        vectors++;
        if (Ins !== 13'h1B00) begin
          miscompares++;
          $display("FAIL straight_ins cycle 6: got %h expected %h", Ins, 13'h1B00);
        end
      end
      tick();
    end
  endtask

  task automatic test_data_memory();
    logic [7:0] exp_pc  [9];
    logic [3:0] exp_stb [9];
    exp_pc  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h02};
    exp_stb = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000,
                4'b0000, 4'b0110, 4'b0000};
    do_reset();
    pm[0] = 13'h1920;  // LD_DM 0x20
    pm[1] = 13'h0A00;  // section-01 ALU op with data-memory operand
    start_prog();
    for (int c = 0; c < 9; c++) begin
      vectors++;
      if (PM_Addr !== exp_pc[c]) begin
        miscompares++;
        $display("FAIL dm_pc cycle %0d: got %h expected %h", c + 1, PM_Addr, exp_pc[c]);
      end
      vectors++;
      if (stb !== exp_stb[c]) begin
        miscompares++;
        $display("FAIL dm_strobes cycle %0d: got %b expected %b", c + 1, stb, exp_stb[c]);
      end
      vectors++;
      if (Running !== 1'b1) begin
        miscompares++;
        $display("FAIL dm_running cycle %0d: got %b expected %b", c + 1, Running, 1'b1);
      end
      tick();
    end
  endtask

  task automatic test_branches();
    logic [7:0] exp_pc [10];
    exp_pc = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h10, 8'h10, 8'h11, 8'h11, 8'h11, 8'h40};
    do_reset();
    pm[8'h00] = 13'h1D10;  // JMP 0x10
    pm[8'h10] = 13'h1E40;  // JZ 0x40, not taken (Zero=0)
    pm[8'h11] = 13'h1E40;  // JZ 0x40, taken (Zero=1)
    start_prog();
    for (int c = 0; c < 10; c++) begin
      vectors++;
      if (PM_Addr !== exp_pc[c]) begin
        miscompares++;
        $display("FAIL branch_pc cycle %0d: got %h expected %h", c + 1, PM_Addr, exp_pc[c]);
      end
      vectors++;
      if (stb !== 4'b0000) begin
        miscompares++;
        $display("FAIL branch_strobes cycle %0d: got %b expected %b", c + 1, stb, 4'b0000);
      end
      if (c == 6) Zero = 1'b1;
      tick();
    end
    Zero = 1'b0;
  endtask

  task automatic test_wrap_halt();
    logic [7:0] exp_pc  [14];
    logic [3:0] exp_stb [14];
    logic       exp_run;
    logic       exp_halt;
    exp_pc  = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00,
                8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    exp_stb = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000,
                4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    do_reset();
    pm[8'h00] = 13'h1DFF;  // JMP 0xFF
    pm[8'hFF] = 13'h1A03;  // LD_IMD, PC+1 wraps to 0
    pm[8'h01] = 13'h1F00;  // HALT
    start_prog();
    for (int c = 0; c < 14; c++) begin
      exp_run  = (c < 12);
      exp_halt = (c >= 12);
      vectors++;
      if (PM_Addr !== exp_pc[c]) begin
        miscompares++;
        $display("FAIL wrap_pc cycle %0d: got %h expected %h", c + 1, PM_Addr, exp_pc[c]);
      end
      vectors++;
      if (stb !== exp_stb[c]) begin
        miscompares++;
        $display("FAIL wrap_strobes cycle %0d: got %b expected %b", c + 1, stb, exp_stb[c]);
      end
      vectors++;
      if (Running !== exp_run) begin
        miscompares++;
        $display("FAIL wrap_running cycle %0d: got %b expected %b", c + 1, Running, exp_run);
      end
      vectors++;
      if (Halted !== exp_halt) begin
        miscompares++;
        $display("FAIL wrap_halted cycle %0d: got %b expected %b", c + 1, Halted, exp_halt);
      end
      // second pass through address 0 executes a plain load
      if (c == 3) pm[8'h00] = 13'h1A02;
      if (c == 4) begin
        // Start during LATCH must be ignored
        Start = 1'b1;
        tick();
        Start = 1'b0;
      end else begin
        tick();
      end
    end
    start_prog();
    vectors++;
    if (PM_Addr !== 8'h00) begin
      miscompares++;
      $display("FAIL restart_pc: got %h expected %h", PM_Addr, 8'h00);
    end
    vectors++;
    if ({Running, Halted} !== 2'b10) begin
      miscompares++;
      $display("FAIL restart_flags: got %b expected %b", {Running, Halted}, 2'b10);
    end
  endtask

  task automatic test_midop_reset();
    do_reset();
    pm[0] = 13'h1A05;  // LD_IMD 0x05
    tick();
    vectors++;
    if ({Running, PM_Addr} !== {1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL idle_hold: got %b/%h expected %b/%h", Running, PM_Addr, 1'b0, 8'h00);
    end
    start_prog();
    tick();
    tick();
    vectors++;
    if (Accu_CE !== 1'b1) begin
      miscompares++;
      $display("FAIL midop_exec_accu: got %b expected %b", Accu_CE, 1'b1);
    end
    #2;
    nRst = 1'b0;
    #1;
    vectors++;
    if (stb !== 4'b0000) begin
      miscompares++;
      $display("FAIL midop_strobes: got %b expected %b", stb, 4'b0000);
    end
    vectors++;
    if ({Running, Halted} !== 2'b00) begin
      miscompares++;
      $display("FAIL midop_flags: got %b expected %b", {Running, Halted}, 2'b00);
    end
    vectors++;
    if ({PM_Addr, Ins} !== {8'h00, 13'h0000}) begin
      miscompares++;
      $display("FAIL midop_regs: got %h/%h expected %h/%h", PM_Addr, Ins, 8'h00, 13'h0000);
    end
    #2;
    nRst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if ({Running, PM_Addr} !== {1'b0, 8'h00}) begin
        miscompares++;
        $display("FAIL post_reset_idle %0d: got %b/%h expected %b/%h", c, Running, PM_Addr, 1'b0, 8'h00);
      end
    end
    start_prog();
    vectors++;
    if ({Running, PM_Addr} !== {1'b1, 8'h00}) begin
      miscompares++;
      $display("FAIL post_reset_fetch: got %b/%h expected %b/%h", Running, PM_Addr, 1'b1, 8'h00);
    end
    tick();
    tick();
    vectors++;
    if ({stb, Ins} !== {4'b0100, 13'h1A05}) begin
      miscompares++;
      $display("FAIL post_reset_exec: got %b/%h expected %b/%h", stb, Ins, 4'b0100, 13'h1A05);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_straight_line();
    test_data_memory();
    test_branches();
    test_wrap_halt();
    test_midop_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
